empipe: RTL and testbench

- Execute-to-memory pipeline stage, directly downstream of the decode-execute pipeline register.
- Captures execute results and control bits, then presents them to the memory stage.
- Runs the data-memory request/acknowledge handshake for loads and stores.
- Raises busy_M upstream so the front of the pipeline holds while an access is outstanding; supports flush and an external stall.

---
 rtl/empipe_pkg.sv | 19 +
 rtl/empipe_memwait_fsm.sv | 64 ++++++
 rtl/register.sv | 22 ++
 rtl/empipe.sv | 78 +++++++
 tb/tb_empipe.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/empipe_pkg.sv
// ============================================================
// empipe_pkg : shared widths and memory-wait state encoding
// Rev 1.0
// ============================================================
`default_nettype none

package empipe_pkg;
  localparam int N_W = 32;
  localparam int M_W = 4;
  localparam int F_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mstate_e;
endpackage

`default_nettype wire

// File: rtl/empipe_memwait_fsm.sv
// ============================================================
// memwait_fsm : data-memory request/ack handshake with timeout
// Rev 1.0
// ============================================================
`default_nettype none

module memwait_fsm
  import empipe_pkg::*;
#(
  parameter int TMO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic stall_i,
  input  logic memop_i,
  input  logic mem_ack_i,
  output logic mem_req_o,
  output logic busy_o,
  output logic abort_o,
  output logic mem_err_o
);
  localparam int CW = $clog2(TMO);

  mstate_e       state_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  always_comb begin
    mem_req_o = (state_q == ST_REQ);
    busy_o    = mem_req_o & ~mem_ack_i;
    abort_o   = busy_o & (cnt_q == CW'(TMO - 1));
    mem_err_o = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (busy_o) begin
      // Still waiting: count, and give up after TMO cycles in REQ
      if (abort_o) begin
        err_q   <= 1'b1;
        state_q <= ST_DONE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (!stall_i) begin
      state_q <= memop_i ? ST_REQ : ST_IDLE;
      cnt_q   <= '0;
    end else if (mem_req_o) begin
      // Acked while downstream stalls: park in DONE so no re-request
      state_q <= ST_DONE;
      cnt_q   <= '0;
    end
  end
endmodule

`default_nettype wire

// File: rtl/register.sv
// ============================================================
// register : generic enabled register with synchronous clear
// Rev 1.0
// ============================================================
`default_nettype none

module register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);
  always_ff @(posedge clk) begin
    if (rst)      out <= '0;
    else if (wen) out <= in;
  end
endmodule

`default_nettype wire

// File: rtl/empipe.sv
// ============================================================
// empipe : execute-to-memory pipeline register and memory handshake
// Rev 1.0
// ============================================================
`default_nettype none

module empipe
  import empipe_pkg::*;
#(
  parameter int N   = N_W,
  parameter int M   = M_W,
  parameter int F   = F_W,
  parameter int TMO = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_M,
  input  logic         stall_M,
  input  logic         valid_E,
  input  logic         pcload_E,
  input  logic         regw_E,
  input  logic         memw_E,
  input  logic         regmem_E,
  input  logic         flag_E,
  input  logic [M-1:0] regScr_E,
  input  logic [N-1:0] aluRes_E,
  input  logic [N-1:0] wdata_E,
  input  logic [F-1:0] flags_E,
  input  logic         mem_ack,
  output logic         valid_M,
  output logic         pcload_M,
  output logic         regw_M,
  output logic         memw_M,
  output logic         regmem_M,
  output logic         flag_M,
  output logic [M-1:0] regScr_M,
  output logic [N-1:0] aluRes_M,
  output logic [N-1:0] wdata_M,
  output logic [F-1:0] flags_M,
  output logic         mem_req,
  output logic         busy_M,
  output logic         mem_err
);
  logic hold, wen, memop_E, abort, clr, clr_ab;

  assign hold    = stall_M | busy_M;
  assign wen     = ~hold;
  assign memop_E = valid_E & (memw_E | regmem_E);
  assign clr     = rst | flush_M;
  // An aborted access turns into a bubble that commits nothing
  assign clr_ab  = clr | abort;

  memwait_fsm #(.TMO(TMO)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_M),
    .stall_i   (stall_M),
    .memop_i   (memop_E),
    .mem_ack_i (mem_ack),
    .mem_req_o (mem_req),
    .busy_o    (busy_M),
    .abort_o   (abort),
    .mem_err_o (mem_err)
  );

  register #(.W(1)) u_valid  (.clk(clk), .rst(clr_ab), .wen(wen), .in(valid_E),  .out(valid_M));
  register #(.W(1)) u_regw   (.clk(clk), .rst(clr_ab), .wen(wen), .in(regw_E),   .out(regw_M));
  register #(.W(1)) u_memw   (.clk(clk), .rst(clr_ab), .wen(wen), .in(memw_E),   .out(memw_M));
  register #(.W(1)) u_pcload (.clk(clk), .rst(clr),    .wen(wen), .in(pcload_E), .out(pcload_M));
  register #(.W(1)) u_regmem (.clk(clk), .rst(clr),    .wen(wen), .in(regmem_E), .out(regmem_M));
  register #(.W(1)) u_flag   (.clk(clk), .rst(clr),    .wen(wen), .in(flag_E),   .out(flag_M));
  register #(.W(M)) u_regscr (.clk(clk), .rst(clr),    .wen(wen), .in(regScr_E), .out(regScr_M));
  register #(.W(N)) u_alures (.clk(clk), .rst(clr),    .wen(wen), .in(aluRes_E), .out(aluRes_M));
  register #(.W(N)) u_wdata  (.clk(clk), .rst(clr),    .wen(wen), .in(wdata_E),  .out(wdata_M));
  register #(.W(F)) u_flags  (.clk(clk), .rst(clr),    .wen(wen), .in(flags_E),  .out(flags_M));
endmodule

`default_nettype wire

// File: tb/tb_empipe.sv
// ============================================================
// tb_empipe : scoreboard bench for the execute-to-memory stage
// Rev 1.0
// ============================================================
`default_nettype none

module tb_empipe;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, flush_M, stall_M, mem_ack;
  logic        valid_E, pcload_E, regw_E, memw_E, regmem_E, flag_E;
  logic [3:0]  regScr_E, flags_E;
  logic [31:0] aluRes_E, wdata_E;
  logic        valid_M, pcload_M, regw_M, memw_M, regmem_M, flag_M;
  logic [3:0]  regScr_M, flags_M;
  logic [31:0] aluRes_M, wdata_M;
  logic        mem_req, busy_M, mem_err;

  always #5 clk = ~clk;

  empipe #(.TMO(TMO)) dut (
    .clk(clk), .rst(rst), .flush_M(flush_M), .stall_M(stall_M),
    .valid_E(valid_E), .pcload_E(pcload_E), .regw_E(regw_E), .memw_E(memw_E),
    .regmem_E(regmem_E), .flag_E(flag_E), .regScr_E(regScr_E),
    .aluRes_E(aluRes_E), .wdata_E(wdata_E), .flags_E(flags_E), .mem_ack(mem_ack),
    .valid_M(valid_M), .pcload_M(pcload_M), .regw_M(regw_M), .memw_M(memw_M),
    .regmem_M(regmem_M), .flag_M(flag_M), .regScr_M(regScr_M),
    .aluRes_M(aluRes_M), .wdata_M(wdata_M), .flags_M(flags_M),
    .mem_req(mem_req), .busy_M(busy_M), .mem_err(mem_err)
  );

  typedef struct {
    bit         chk;
    logic [5:0] ctl;   // {valid,pcload,regw,memw,regmem,flag}
    logic [3:0] rs;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0] fl;
    logic       req;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   first    = 1'b1;

  // Reference model: the held instruction plus an "access pending" flag
  logic [5:0]  m_ctl;
  logic [3:0]  m_rs, m_fl;
  logic [31:0] m_alu, m_wd;
  bit          m_pend, m_err;
  int          m_wait;

  task automatic rand_E();
    valid_E  = ($urandom_range(3) != 0);
    pcload_E = 1'($urandom);
    regw_E   = 1'($urandom);
    memw_E   = ($urandom_range(2) == 0);
    regmem_E = ($urandom_range(2) == 0);
    flag_E   = 1'($urandom);
    regScr_E = 4'($urandom);
    aluRes_E = $urandom;
    wdata_E  = $urandom;
    flags_E  = 4'($urandom);
  endtask

  task automatic quiet();
    rst = 0; flush_M = 0; stall_M = 0; mem_ack = 0;
    rand_E();
    valid_E = 0;
  endtask

  task automatic alu_E(input logic [31:0] a);
    rand_E();
    valid_E = 1; regw_E = 1; memw_E = 0; regmem_E = 0; aluRes_E = a;
  endtask

  // Push this cycle's expected outputs, advance the model, then step one clock
  task automatic cycle();
    exp_t e;
    bit   hold;
    e.chk  = !first;
    e.ctl  = m_ctl; e.rs = m_rs; e.alu = m_alu; e.wd = m_wd; e.fl = m_fl;
    e.req  = m_pend;
    e.busy = m_pend && !mem_ack;
    e.err  = m_err;
    q.push_back(e);

    if (rst) begin
      m_ctl = '0; m_rs = '0; m_alu = '0; m_wd = '0; m_fl = '0;
      m_pend = 0; m_wait = 0; m_err = 0;
    end else if (flush_M) begin
      m_ctl = '0; m_rs = '0; m_alu = '0; m_wd = '0; m_fl = '0;
      m_pend = 0; m_wait = 0;
    end else begin
      hold = stall_M || (m_pend && !mem_ack);
      if (m_pend && !mem_ack) begin
        if (m_wait == TMO - 1) begin
          m_err = 1; m_pend = 0; m_wait = 0;
          m_ctl[5] = 0; m_ctl[3] = 0; m_ctl[2] = 0;
        end else begin
          m_wait++;
        end
      end else if (m_pend && mem_ack && stall_M) begin
        m_pend = 0;
      end
      if (!hold) begin
        m_ctl  = {valid_E, pcload_E, regw_E, memw_E, regmem_E, flag_E};
        m_rs   = regScr_E; m_alu = aluRes_E; m_wd = wdata_E; m_fl = flags_E;
        m_pend = valid_E && (memw_E || regmem_E);
        m_wait = 0;
      end
    end
    first = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          chk("ctl", 32'({valid_M, pcload_M, regw_M, memw_M, regmem_M, flag_M}), 32'(e.ctl));
          chk("regScr_M", 32'(regScr_M), 32'(e.rs));
          chk("aluRes_M", aluRes_M, e.alu);
          chk("wdata_M", wdata_M, e.wd);
          chk("flags_M", 32'(flags_M), 32'(e.fl));
          chk("mem_req", 32'(mem_req), 32'(e.req));
          chk("busy_M", 32'(busy_M), 32'(e.busy));
          chk("mem_err", 32'(mem_err), 32'(e.err));
        end
      end
    end
  end

  initial begin : stim
    int ackp;
    m_ctl = '0; m_rs = '0; m_alu = '0; m_wd = '0; m_fl = '0;
    m_pend = 0; m_err = 0; m_wait = 0;
    rst = 1; flush_M = 0; stall_M = 0; mem_ack = 0;
    rand_E();
    @(posedge clk);
    #1;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      rand_E();
      rst = 1; flush_M = 1'($urandom); stall_M = 1'($urandom); mem_ack = 1'($urandom);
      cycle();
    end

    // ALU stream
    quiet();
    for (int i = 0; i < 3; i++) begin
      alu_E(32'h10 + 32'(i));
      cycle();
    end
    quiet(); cycle();

    // Store acked on its third REQ cycle; next instruction loads on the ack edge
    rand_E();
    valid_E = 1; memw_E = 1; regmem_E = 0; aluRes_E = 32'h100; wdata_E = 32'hDEADBEEF;
    cycle();
    alu_E(32'h20);
    cycle();
    cycle();
    mem_ack = 1;
    cycle();
    quiet(); cycle(); cycle();

    // Load acked while stalled, then released
    rand_E();
    valid_E = 1; regmem_E = 1; memw_E = 0;
    cycle();
    alu_E(32'h30);
    stall_M = 1; mem_ack = 1;
    cycle();
    mem_ack = 0;
    cycle();
    stall_M = 0;
    cycle();
    quiet(); cycle();

    // Timeout with no ack
    rand_E();
    valid_E = 1; memw_E = 1; regw_E = 1;
    cycle();
    alu_E(32'h40);
    for (int i = 0; i < 20; i++) cycle();
    quiet(); cycle(); cycle();

    // Flush mid-REQ, together with stall
    rand_E();
    valid_E = 1; regmem_E = 1;
    cycle();
    alu_E(32'h50);
    cycle();
    flush_M = 1; stall_M = 1;
    cycle();
    quiet(); cycle(); cycle();

    // Random traffic with memory speed varying per window
    for (int w = 0; w < 30; w++) begin
      case ($urandom_range(3))
        0: ackp = 0;
        1: ackp = 10;
        2: ackp = 50;
        default: ackp = 90;
      endcase
      for (int i = 0; i < 100; i++) begin
        rand_E();
        rst     = ($urandom_range(199) == 0);
        flush_M = ($urandom_range(19) == 0);
        stall_M = ($urandom_range(3) == 0);
        mem_ack = ($urandom_range(99) < ackp);
        cycle();
      end
    end

    // Final reset clears the sticky error
    quiet(); rst = 1; cycle();
    quiet(); cycle(); cycle();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
